lane_serializer_4x32: RTL and testbench
=======================================

LANE_SERIALIZER_4X32 -- requirements
Module: lane_serializer_4x32

Interface
REQ-001 The block SHALL have exactly one clock, clk, and one asynchronous active-low reset, rst.
REQ-002 Port list (name, direction, width, meaning):
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-low reset
- start  input  1  request to capture in0..in3 and begin a frame
- in0, in1, in2, in3  input  32 each  parallel words to serialize
- out_data  output  32  current word
- out_idx  output  2  index of current word (0..3)
- out_valid  output  1  out_data/out_idx are valid
- out_ready  input  1  consumer accepts the current word
- out_last  output  1  current word is word 3
- busy  output  1  frame in progress
- done  output  1  one-cycle pulse after the final transfer
- overrun  output  1  sticky flag: start arrived while busy
REQ-003 Parameters (name, default, meaning): WIDTH, 32, word width; WORDS, 4, words per frame (fixed; not overridable).

Function
REQ-004 The state machine SHALL have two states, IDLE and SEND.
REQ-005 In IDLE with start=1 at edge N, the block SHALL capture in0..in3 into an internal bank, enter SEND, and assert out_valid with out_idx=0 at edge N.
- Latency: one cycle from start to the first valid word.
REQ-006 A transfer SHALL occur on each edge where out_valid=1 and out_ready=1.
- On a transfer, out_idx SHALL advance by 1.
REQ-007 While out_valid=1 and out_ready=0, out_data, out_idx and out_last SHALL hold stable.
REQ-008 out_data SHALL equal the captured word selected by out_idx; inputs changing during SEND SHALL NOT affect out_data.
REQ-009 out_last SHALL equal out_valid AND (out_idx==3).
REQ-010 On the transfer of word 3, the block SHALL:
- return to IDLE;
- deassert out_valid;
- pulse done high for exactly one cycle.
REQ-011 busy SHALL be 1 exactly when the state is SEND.
REQ-012 When start=1 in SEND, including the cycle of the final transfer, the start SHALL be ignored and overrun SHALL be set.
REQ-013 overrun SHALL remain set until the next accepted start, which SHALL clear it.
REQ-014 out_idx SHALL NOT wrap within a frame; the next frame SHALL restart at 0.
REQ-015 Maximum throughput SHALL be 4 words in 4 consecutive cycles, followed by one mandatory IDLE cycle before the next start is accepted.

Reset
REQ-016 Asserting rst=0 at any time SHALL immediately force:
- state to IDLE;
- out_valid, busy, done, overrun, out_last, out_idx to 0;
- out_data and the internal bank to 32'h0000_0000.
REQ-017 A frame interrupted by reset SHALL be abandoned and SHALL NOT resume after reset is released.
REQ-018 Reset release SHALL be synchronous to clk: the first start is accepted on the first edge after rst returns to 1.

Configuration
REQ-019 With SERIALIZER_PARITY_EN defined, the block SHALL add output out_parity (1 bit).
- out_parity = even parity (XOR reduction) of out_data.
- out_parity is registered with out_data, follows the same hold rules, and resets to 0.
REQ-020 Without SERIALIZER_PARITY_EN, out_parity SHALL be absent and all other behaviour SHALL be identical.

Structure
REQ-021 A shared package serializer_pkg SHALL hold:
- the state enumeration (IDLE, SEND);
- constants SER_WIDTH=32 and SER_WORDS=4;
- the index type (2 bits).
REQ-022 Word selection SHALL be a sub-module word_mux4 (four WIDTH inputs, 2-bit select, one output).
- All sequencing and registers SHALL stay in lane_serializer_4x32.

Verification
REQ-023 Directed scenarios:
- Basic: in0..3=32'h11111111/22222222/33333333/44444444, start pulse, out_ready=1 constantly -> words in order over 4 cycles; out_last on the 4th; done pulse on the following cycle.
- Backpressure: same frame, out_ready=0 for 3 cycles on word 1 -> out_data=32'h22222222 and out_idx=1 held stable; no word skipped or duplicated.
- Input change: in0..in3 changed to 32'hDEADBEEF during SEND -> serialized words remain the captured values.
- Overrun: start pulsed at word 2 -> ignored; overrun=1 until the next accepted start, then 0.
- Reset mid-frame: rst=0 during word 2 -> all outputs 0 immediately; after release, new start -> frame begins at out_idx=0.
- Parity (SERIALIZER_PARITY_EN): out_data=32'h00000001 -> out_parity=1; 32'h00000003 -> out_parity=0.

Source files
------------

// File: rtl/serializer_pkg.sv
// serializer_pkg
//   Shared types and constants for the 4-word lane serializer.
//   - state_t : serializer FSM states (IDLE, SEND)
//   - idx_t   : word index within a frame (2 bits)
//   - SER_WIDTH / SER_WORDS : word width and words per frame
package serializer_pkg;

  localparam int SER_WIDTH = 32;
  localparam int SER_WORDS = 4;

  typedef logic [1:0] idx_t;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  localparam idx_t LAST_IDX = idx_t'(SER_WORDS - 1);

endpackage

// File: rtl/lane_serializer_4x32_word_mux4.sv
// word_mux4
//   Four-way word selector used to pick the next captured word.
//   Ports:
//     d0..d3 : input  [WIDTH-1:0] candidate words
//     sel    : input  idx_t       word select
//     y      : output [WIDTH-1:0] selected word
module word_mux4
  import serializer_pkg::*;
#(
  parameter int WIDTH = SER_WIDTH
) (
  input  logic [WIDTH-1:0] d0,
  input  logic [WIDTH-1:0] d1,
  input  logic [WIDTH-1:0] d2,
  input  logic [WIDTH-1:0] d3,
  input  idx_t             sel,
  output logic [WIDTH-1:0] y
);

  always_comb begin
    y = d0;
    case (sel)
      2'd0: y = d0;
      2'd1: y = d1;
      2'd2: y = d2;
      2'd3: y = d3;
      default: y = d0;
    endcase
  end

endmodule

// File: rtl/lane_serializer_4x32.sv
// lane_serializer_4x32
//   Captures four parallel words on start and presents them one at a time
//   on a valid/ready output port, word 0 first.
//   Optional feature: define SERIALIZER_PARITY_EN to add out_parity
//   (XOR reduction of out_data, registered alongside it).
//   Ports:
//     clk        : input  rising-edge clock
//     rst        : input  asynchronous active-low reset
//     start      : input  capture in0..in3 and begin a frame (honoured in IDLE)
//     in0..in3   : input  [WIDTH-1:0] words to serialize
//     out_data   : output [WIDTH-1:0] current word
//     out_idx    : output [1:0] index of current word
//     out_valid  : output out_data/out_idx valid
//     out_ready  : input  consumer accepts current word
//     out_last   : output current word is word 3
//     busy       : output frame in progress
//     done       : output one-cycle pulse after the final transfer
//     overrun    : output sticky, start seen while busy; cleared by next accepted start
//     out_parity : output (SERIALIZER_PARITY_EN only) parity of out_data
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   IDLE  | no frame; start captures the bank and presents word 0
//   SEND  | frame in progress; each valid&ready edge advances out_idx
module lane_serializer_4x32
  import serializer_pkg::*;
#(
  parameter int WIDTH = SER_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] in0,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic [WIDTH-1:0] in3,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       out_idx,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_last,
  output logic             busy,
  output logic             done,
  output logic             overrun
`ifdef SERIALIZER_PARITY_EN
  ,
  output logic             out_parity
`endif
);

  state_t           state;
  logic [WIDTH-1:0] bank0, bank1, bank2, bank3;
  idx_t             next_idx;
  logic [WIDTH-1:0] next_word;
  logic             xfer;
  logic             par_q;

  assign next_idx = out_idx + 2'd1;
  assign xfer     = out_valid & out_ready;

  word_mux4 #(.WIDTH(WIDTH)) u_mux (
    .d0  (bank0),
    .d1  (bank1),
    .d2  (bank2),
    .d3  (bank3),
    .sel (next_idx),
    .y   (next_word)
  );

`ifdef SERIALIZER_PARITY_EN
  assign out_parity = par_q;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      bank0     <= '0;
      bank1     <= '0;
      bank2     <= '0;
      bank3     <= '0;
      out_data  <= '0;
      out_idx   <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      overrun   <= 1'b0;
      par_q     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            bank0     <= in0;
            bank1     <= in1;
            bank2     <= in2;
            bank3     <= in3;
            out_data  <= in0;
            par_q     <= ^in0;
            out_idx   <= '0;
            out_valid <= 1'b1;
            out_last  <= 1'b0;
            busy      <= 1'b1;
            overrun   <= 1'b0;
            state     <= SEND;
          end
        end
        SEND: begin
          // A start during SEND is dropped, even on the final-transfer edge.
          if (start) overrun <= 1'b1;
          if (xfer) begin
            if (out_idx == LAST_IDX) begin
              state     <= IDLE;
              out_valid <= 1'b0;
              out_last  <= 1'b0;
              busy      <= 1'b0;
              done      <= 1'b1;
              out_idx   <= '0;
              out_data  <= '0;
              par_q     <= 1'b0;
            end else begin
              out_idx  <= next_idx;
              out_data <= next_word;
              par_q    <= ^next_word;
              out_last <= (next_idx == LAST_IDX);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifndef SERIALIZER_PARITY_EN
  // Parity register is dead logic in this build; keep it tied into a sink.
  logic unused_par;
  assign unused_par = par_q;
`endif

endmodule

// File: tb/tb_lane_serializer_4x32.sv
module tb_lane_serializer_4x32;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] in0, in1, in2, in3;
  logic [31:0] out_data;
  logic [1:0]  out_idx;
  logic        out_valid;
  logic        out_ready;
  logic        out_last;
  logic        busy;
  logic        done;
  logic        overrun;
`ifdef SERIALIZER_PARITY_EN
  logic        out_parity;
`endif

  always #5 clk = ~clk;

  lane_serializer_4x32 dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .in0       (in0),
    .in1       (in1),
    .in2       (in2),
    .in3       (in3),
    .out_data  (out_data),
    .out_idx   (out_idx),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_last  (out_last),
    .busy      (busy),
    .done      (done),
    .overrun   (overrun)
`ifdef SERIALIZER_PARITY_EN
    ,
    .out_parity(out_parity)
`endif
  );

  int checks = 0;
  int errors = 0;

  // Reference: words still owed to the consumer in the current frame.
  logic [31:0] q[$];
  logic        m_ovr  = 1'b0;
  logic        m_done = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".valid"}, 32'(out_valid), 32'(q.size() != 0));
    chk({tag, ".busy"},  32'(busy),      32'(q.size() != 0));
    chk({tag, ".last"},  32'(out_last),  32'(q.size() == 1));
    chk({tag, ".done"},  32'(done),      32'(m_done));
    chk({tag, ".ovr"},   32'(overrun),   32'(m_ovr));
    if (q.size() != 0) begin
      chk({tag, ".data"}, out_data,     q[0]);
      chk({tag, ".idx"},  32'(out_idx), 32'(4 - q.size()));
`ifdef SERIALIZER_PARITY_EN
      chk({tag, ".par"},  32'(out_parity), 32'(^q[0]));
`endif
    end
  endtask

  // Apply the current inputs to the reference for the coming edge.
  task automatic model_edge();
    bit was_busy;
    bit xfer;
    was_busy = (q.size() != 0);
    xfer     = was_busy && out_ready;
    m_done   = xfer && (q.size() == 1);
    if (start && was_busy) m_ovr = 1'b1;
    if (xfer) void'(q.pop_front());
    if (start && !was_busy) begin
      q = {in0, in1, in2, in3};
      m_ovr = 1'b0;
    end
  endtask

  task automatic cycle(input string tag);
    model_edge();
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  task automatic set_words(input logic [31:0] a, b, c, d);
    in0 = a; in1 = b; in2 = c; in3 = d;
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; out_ready = 1'b0;
    set_words(32'h0, 32'h0, 32'h0, 32'h0);
    #1;
    chk("rst.data",  out_data,        32'h0);
    chk("rst.idx",   32'(out_idx),    32'h0);
    chk("rst.valid", 32'(out_valid),  32'h0);
    chk("rst.busy",  32'(busy),       32'h0);
    chk("rst.done",  32'(done),       32'h0);
    chk("rst.ovr",   32'(overrun),    32'h0);
    chk("rst.last",  32'(out_last),   32'h0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;

    // Basic frame, consumer always ready.
    set_words(32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444);
    start = 1'b1; out_ready = 1'b1;
    cycle("basic.start");
    chk("basic.w0", out_data, 32'h11111111);
    start = 1'b0;
    for (int i = 0; i < 4; i++) cycle("basic.run");
    chk("basic.donepulse", 32'(done), 32'h1);
    cycle("basic.after");
    chk("basic.doneclr", 32'(done), 32'h0);

    // Backpressure on word 1 for three cycles.
    start = 1'b1;
    cycle("bp.start");
    start = 1'b0;
    cycle("bp.w1");
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cycle("bp.hold");
      chk("bp.holddata", out_data, 32'h22222222);
      chk("bp.holdidx",  32'(out_idx), 32'h1);
    end
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) cycle("bp.run");

    // Inputs change during SEND.
    set_words(32'hA0A0A0A0, 32'hB1B1B1B1, 32'hC2C2C2C2, 32'hD3D3D3D3);
    start = 1'b1;
    cycle("chg.start");
    start = 1'b0;
    set_words(32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF);
    for (int i = 0; i < 3; i++) cycle("chg.run");
    chk("chg.w3", out_data, 32'hD3D3D3D3);
    cycle("chg.end");

    // Overrun at word 2, sticky through idle, cleared by next start.
    set_words(32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444);
    start = 1'b1;
    cycle("ovr.start");
    start = 1'b0;
    cycle("ovr.w1");
    start = 1'b1;
    cycle("ovr.w2");
    chk("ovr.set", 32'(overrun), 32'h1);
    start = 1'b0;
    for (int i = 0; i < 4; i++) cycle("ovr.idle");
    start = 1'b1;
    cycle("ovr.restart");
    chk("ovr.clr", 32'(overrun), 32'h0);
    start = 1'b0;
    for (int i = 0; i < 4; i++) cycle("ovr.run");

    // Start held high: final-transfer edge ignores it, next edge accepts.
    start = 1'b1;
    for (int i = 0; i < 12; i++) cycle("b2b");
    start = 1'b0;
    for (int i = 0; i < 5; i++) cycle("b2b.drain");

    // Reset during word 2.
    start = 1'b1;
    cycle("rmf.start");
    start = 1'b0;
    cycle("rmf.w1");
    cycle("rmf.w2");
    #2;
    rst = 1'b0;
    #1;
    q.delete(); m_ovr = 1'b0; m_done = 1'b0;
    chk("rmf.data",  out_data,       32'h0);
    chk("rmf.idx",   32'(out_idx),   32'h0);
    chk("rmf.valid", 32'(out_valid), 32'h0);
    chk("rmf.busy",  32'(busy),      32'h0);
    chk("rmf.last",  32'(out_last),  32'h0);
    @(posedge clk);
    #1;
    check_all("rmf.held");
    @(negedge clk);
    rst = 1'b1;
    set_words(32'h55555555, 32'h66666666, 32'h77777777, 32'h88888888);
    start = 1'b1;
    cycle("rmf.restart");
    chk("rmf.idx0", 32'(out_idx), 32'h0);
    start = 1'b0;
    for (int i = 0; i < 4; i++) cycle("rmf.run");

    // Parity-sensitive words.
    set_words(32'h00000001, 32'h00000003, 32'h80000000, 32'hFFFFFFFF);
    start = 1'b1;
    cycle("par.start");
`ifdef SERIALIZER_PARITY_EN
    chk("par.one", 32'(out_parity), 32'h1);
`endif
    start = 1'b0;
    cycle("par.w1");
`ifdef SERIALIZER_PARITY_EN
    chk("par.three", 32'(out_parity), 32'h0);
`endif
    for (int i = 0; i < 3; i++) cycle("par.run");

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      start     = ($urandom_range(0, 3) == 0);
      out_ready = ($urandom_range(0, 9) < 7);
      set_words($urandom, $urandom, $urandom, $urandom);
      cycle("rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
